// File: rtl/tt_um_serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and
// the helper that sizes the bit counter.
package tt_um_serial_subtractor_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    typedef enum logic {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT
    } state_t;

    // Counter must hold 0..width-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/tt_um_serial_subtractor_if.sv
// Operand/result bundle for the serial subtractor.
// Handshake: start is a request sampled only while idle with ena=1 (no
// ready signal; busy=1 means requests are dropped). done is a one-cycle
// valid strobe for diff_out/bout/ovf, stretched while ena=0.
interface tt_um_serial_subtractor_if
    import tt_um_serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             ena;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             bin;
    logic [WIDTH-1:0] diff_out;
    logic             bout;
    logic             ovf;
    logic             busy;
    logic             done;
    state_t           state_dbg;

    modport master (
        output ena, start, a_in, b_in, bin,
        input  diff_out, bout, ovf, busy, done, state_dbg
    );

    modport slave (
        input  ena, start, a_in, b_in, bin,
        output diff_out, bout, ovf, busy, done, state_dbg
    );

endinterface

// File: rtl/tt_um_serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = a - b - bi, bo = borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: A - B - Bin, one bit per enabled
// clock, LSB first, with a start/done handshake.
module tt_um_serial_subtractor
    import tt_um_serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    tt_um_serial_subtractor_if.slave  bus
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nxt;
    logic             brw;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;
    logic             d_bit;
    logic             bo_bit;
    logic             last;

    full_subtractor u_fs (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .bi (brw),
        .d  (d_bit),
        .bo (bo_bit)
    );

    assign last    = (cnt == CW'(WIDTH - 1));
    // New difference bit enters at the MSB so the LSB ends up at bit 0.
    assign res_nxt = (res >> 1) | {d_bit, {(WIDTH-1){1'b0}}};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (last)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            brw    <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (bus.ena) begin
            state  <= state_nxt;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh   <= bus.a_in;
                        b_sh   <= bus.b_in;
                        brw    <= bus.bin;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    res  <= res_nxt;
                    brw  <= bo_bit;
                    if (last) begin
                        // brw here is still the borrow into the MSB.
                        diff_q <= res_nxt;
                        bout_q <= bo_bit;
                        ovf_q  <= brw ^ bo_bit;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.diff_out  = diff_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.state_dbg = state;

endmodule
